weight_feeder: RTL

- North/west-edge driver for the systolic PE array: the transmitter side of the PE weight-load and switch interface.
- Collects one full weight tile from a valid/ready stream into an internal buffer.
- Bursts the tile down every column with accept_w held continuously. A PE zeroes its weight output when not accepting, so the burst must never stall.
- On request, emits the row-skewed switch pulse that moves the tile into the PEs' active weight registers.

---
 rtl/weight_feeder.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/weight_feeder.sv
// Weight feeder for the systolic PE array: buffers one weight tile from a
// valid/ready stream, bursts it down every column, then issues the row-skewed switch.
module weight_feeder #(
   parameter int ROWS       = 2,
   parameter int COLS       = 2,
   parameter int DATA_WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       w_valid,
   output logic                       w_ready,
   input  logic [COLS*DATA_WIDTH-1:0] w_data,
   input  logic                       switch_req,
   output logic [COLS*DATA_WIDTH-1:0] weight_out,
   output logic [COLS-1:0]            accept_w_out,
   output logic [ROWS-1:0]            switch_out,
   output logic                       loaded,
   output logic                       busy
);

   localparam int W  = COLS * DATA_WIDTH;
   localparam int CW = $clog2(ROWS + 1);
   localparam logic [CW-1:0] LAST_ROW = CW'(ROWS - 1);

   // The switch skew runs alongside FILL; it is tracked by skew_q, not a state.
   typedef enum logic [1:0] {
      ST_FILL,
      ST_BURST,
      ST_LOADED
   } state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [W-1:0]    tile_q [ROWS];
   logic [W-1:0]    tile_d [ROWS];
   logic [W-1:0]    weight_out_q, weight_out_d;
   logic [COLS-1:0] accept_q, accept_d;
   logic [ROWS-1:0] skew_q, skew_d;
   logic            loaded_q, loaded_d;
   logic            w_ready_q, w_ready_d;
   logic            busy_q, busy_d;

   logic            handshake;
   logic [W-1:0]    first_slot;

   assign handshake = w_valid && w_ready_q;

   // With a single row, slot 0 is the beat being written in this very cycle.
   assign first_slot = (ROWS == 1) ? w_data : tile_q[0];

   always_comb begin
      // NOTE: every signal gets a default here so no path leaves it unassigned (no latch).
      state_d      = state_q;
      cnt_d        = cnt_q;
      tile_d       = tile_q;
      weight_out_d = '0;
      accept_d     = '0;
      loaded_d     = 1'b0;
      skew_d       = skew_q << 1;

      unique case (state_q)
         ST_FILL: begin
            if (handshake) begin
               for (int k = 0; k < ROWS; k++) begin
                  if (cnt_q == CW'(k)) begin
                     tile_d[k] = w_data;
                  end
               end
               if (cnt_q == LAST_ROW) begin
                  state_d      = ST_BURST;
                  cnt_d        = '0;
                  weight_out_d = first_slot;
                  accept_d     = '1;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end

         // cnt_q is the slot currently on weight_out; the next slot is staged each cycle.
         ST_BURST: begin
            if (cnt_q == LAST_ROW) begin
               state_d  = ST_LOADED;
               cnt_d    = '0;
               loaded_d = 1'b1;
            end else begin
               for (int k = 0; k < ROWS; k++) begin
                  if (cnt_q + CW'(1) == CW'(k)) begin
                     weight_out_d = tile_q[k];
                  end
               end
               accept_d = '1;
               cnt_d    = cnt_q + CW'(1);
            end
         end

         ST_LOADED: begin
            loaded_d = 1'b1;
            if (switch_req) begin
               state_d   = ST_FILL;
               loaded_d  = 1'b0;
               skew_d[0] = 1'b1;
            end
         end

         default: begin
            state_d = ST_FILL;
            cnt_d   = '0;
         end
      endcase

      // Hold off the final beat until the skew drains so a burst never overlaps it.
      w_ready_d = (state_d == ST_FILL) && !((cnt_d == LAST_ROW) && (skew_d != '0));
      busy_d    = (state_d == ST_BURST) || (skew_d != '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_FILL;
         cnt_q        <= '0;
         // NOTE: the tile buffer is small and its contents are observable, so it is reset too.
         for (int k = 0; k < ROWS; k++) begin
            tile_q[k] <= '0;
         end
         weight_out_q <= '0;
         accept_q     <= '0;
         skew_q       <= '0;
         loaded_q     <= 1'b0;
         w_ready_q    <= 1'b1;
         busy_q       <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge values.
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         tile_q       <= tile_d;
         weight_out_q <= weight_out_d;
         accept_q     <= accept_d;
         skew_q       <= skew_d;
         loaded_q     <= loaded_d;
         w_ready_q    <= w_ready_d;
         busy_q       <= busy_d;
      end
   end

   assign w_ready      = w_ready_q;
   assign weight_out   = weight_out_q;
   assign accept_w_out = accept_q;
   assign switch_out   = skew_q;
   assign loaded       = loaded_q;
   assign busy         = busy_q;

endmodule
